// File: rtl/iurt_pkg.sv
// Shared definitions for the IURT up-channel arbiter: FSM state encoding and tag byte base.
// The tag byte layout (TAG_BASE | grant) is only used when IURT_ARB_TAG_EN is defined.
package iurt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_TAG  = 2'd1,
        ST_SEND_DATA = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_e;

    localparam logic [7:0] TAG_BASE = 8'hF0;
    localparam int         GRANT_W  = 4;

    function automatic logic [7:0] make_tag(input logic [GRANT_W-1:0] grant);
        return TAG_BASE | {4'h0, grant};
    endfunction

endpackage

// File: rtl/iurt_rr_pick.sv
// Round-robin picker: first set request starting at last_grant+1, wrapping at N_REQ-1 to 0.
module iurt_rr_pick
    import iurt_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req_i,
    input  logic [GRANT_W-1:0] last_grant_i,
    output logic [GRANT_W-1:0] grant_o,
    output logic               any_o
);

    logic [15:0] req_pad;
    logic [4:0]  cand;

    assign req_pad = 16'(req_i);

    // Scan from the farthest offset down so the nearest hit is written last and wins.
    always_comb begin
        grant_o = last_grant_i;
        any_o   = 1'b0;
        cand    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = {1'b0, last_grant_i} + 5'(off);
            if (cand >= 5'(N_REQ)) begin
                cand = cand - 5'(N_REQ);
            end
            if (req_pad[cand[3:0]]) begin
                grant_o = cand[3:0];
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iurt_up_arbiter.sv
// Byte up-channel arbiter: N_REQ one-byte holding registers served round-robin onto one channel.
// Define IURT_ARB_TAG_EN to precede every data byte with a tag byte carrying the requester index.
module iurt_up_arbiter
    import iurt_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               data_up_ready,
    output logic               data_up_valid,
    output logic [7:0]         data_up,
    output logic               busy
);

    arb_state_e         state_q;
    logic [GRANT_W-1:0] grant_q;
    logic [GRANT_W-1:0] last_grant_q;
    logic [GRANT_W-1:0] pick_grant;
    logic               pick_any;
    logic               tag_phase_q;
    logic               valid_q;
    logic [7:0]         data_q;
    logic [N_REQ-1:0]   full_q;
    logic [N_REQ-1:0]   full_d;
    logic [N_REQ-1:0]   cap;
    logic [N_REQ-1:0]   clr;
    logic [7:0]         hold_q [N_REQ];
    logic [7:0]         sel_byte;
    logic               retire;

    assign req_ready     = ~full_q;
    assign busy          = (state_q != ST_IDLE);
    assign data_up_valid = valid_q;
    assign data_up       = data_q;

    // A holding register is released only in the GAP that follows its data byte.
    assign retire = ce && (state_q == ST_GAP) && !tag_phase_q;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign cap[gi] = ce & req_valid[gi] & ~full_q[gi];
            assign clr[gi] = retire && (grant_q == GRANT_W'(gi));
        end
    endgenerate

    assign full_d = (full_q | cap) & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    // Holding data has no reset; its content is only meaningful while the full flag is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (cap[i]) begin
                hold_q[i] <= req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        sel_byte = hold_q[0];
        for (int i = 1; i < N_REQ; i++) begin
            if (grant_q == GRANT_W'(i)) begin
                sel_byte = hold_q[i];
            end
        end
    end

    iurt_rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req_i       (full_q),
        .last_grant_i(last_grant_q),
        .grant_o     (pick_grant),
        .any_o       (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(N_REQ - 1);
            tag_phase_q  <= 1'b0;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else if (ce) begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_grant;
`ifdef IURT_ARB_TAG_EN
                        state_q <= ST_SEND_TAG;
`else
                        state_q <= ST_SEND_DATA;
`endif
                    end
                end
`ifdef IURT_ARB_TAG_EN
                ST_SEND_TAG: begin
                    if (data_up_ready) begin
                        valid_q     <= 1'b1;
                        data_q      <= make_tag(grant_q);
                        tag_phase_q <= 1'b1;
                        state_q     <= ST_GAP;
                    end
                end
`endif
                ST_SEND_DATA: begin
                    if (data_up_ready) begin
                        valid_q     <= 1'b1;
                        data_q      <= sel_byte;
                        tag_phase_q <= 1'b0;
                        state_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tag_phase_q) begin
                        state_q <= ST_SEND_DATA;
                    end else begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iurt_up_arbiter.sv
// Self-checking bench for iurt_up_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model of the arbiter.
module tb_iurt_up_arbiter;

    localparam int N = 4;
`ifdef IURT_ARB_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ce = 1'b1;
    logic           data_up_ready = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           data_up_valid;
    logic [7:0]     data_up;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    iurt_up_arbiter #(.N_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .data_up_ready(data_up_ready),
        .data_up_valid(data_up_valid),
        .data_up      (data_up),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: each grant expands into a list of beats to play out.
    // Beat codes: 0 emit tag, 1 emit data, 2 idle beat, 3 idle beat then release the requester.
    bit         m_full [N];
    logic [7:0] m_byte [N];
    int         m_last = N - 1;
    int         m_grant = 0;
    int         beats [$];
    logic [N-1:0] m_cap;
    bit         m_pulse;
    logic [7:0] m_pv;
    bit         e_valid = 1'b0;
    bit         e_busy = 1'b0;
    bit         e_known = 1'b0;
    logic [7:0] e_data = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            beats.delete();
            m_last  = N - 1;
            e_valid = 1'b0;
            e_busy  = 1'b0;
            e_known = 1'b0;
        end else if (ce) begin
            m_pulse = 1'b0;
            m_pv    = 8'h00;
            for (int i = 0; i < N; i++) m_cap[i] = req_valid[i] && !m_full[i];
            if (beats.size() == 0) begin
                for (int o = 1; o <= N; o++) begin
                    int j;
                    j = (m_last + o) % N;
                    if (m_full[j]) begin
                        m_grant = j;
                        if (TAG) begin
                            beats.push_back(0);
                            beats.push_back(2);
                        end
                        beats.push_back(1);
                        beats.push_back(3);
                        break;
                    end
                end
            end else begin
                case (beats[0])
                    0: if (data_up_ready) begin
                        m_pulse = 1'b1;
                        m_pv = 8'(8'hF0 + m_grant);
                        void'(beats.pop_front());
                    end
                    1: if (data_up_ready) begin
                        m_pulse = 1'b1;
                        m_pv = m_byte[m_grant];
                        void'(beats.pop_front());
                    end
                    2: void'(beats.pop_front());
                    default: begin
                        void'(beats.pop_front());
                        m_full[m_grant] = 1'b0;
                        m_last = m_grant;
                    end
                endcase
            end
            e_valid = m_pulse;
            if (m_pulse) begin
                e_data  = m_pv;
                e_known = 1'b1;
            end
            e_busy = (beats.size() != 0);
            for (int i = 0; i < N; i++) begin
                if (m_cap[i]) begin
                    m_full[i] = 1'b1;
                    m_byte[i] = req_data[8*i +: 8];
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) er[i] = !m_full[i];
        chk("model_valid", data_up_valid, e_valid);
        chk("model_busy", busy, e_busy);
        chk("model_ready", req_ready, er);
        if (e_known) chk("model_data", data_up, e_data);
    end

    typedef struct {
        int         c;
        logic [7:0] b;
    } pulse_t;
    pulse_t pulses [$];

    always @(negedge clk) begin
        if (data_up_valid) pulses.push_back('{cyc, data_up});
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    logic [7:0] exp_b [$];

    initial begin
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 4'hF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", data_up_valid, 1'b0);

        // Single byte from requester 2, channel ready.
        next_cycle();
        data_up_ready = 1'b1;
        req_valid = 4'b0100;
        req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("a_ready_after_cap", req_ready, 4'b1011);
        next_cycle();
        @(negedge clk);
        chk("a_no_pulse_k1", data_up_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("a_pulse_k2", data_up_valid, 1'b1);
        chk("a_byte_k2", data_up, TAG ? 8'hF2 : 8'hA5);
        run(10);

        // All four full at once after reset: serve order 0,1,2,3.
        do_reset();
        pulses.delete();
        data_up_ready = 1'b1;
        req_valid = 4'hF;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        next_cycle();
        req_valid = '0;
        run(40);
        for (int i = 0; i < N; i++) begin
            if (TAG) exp_b.push_back(8'(8'hF0 + i));
            exp_b.push_back(8'(8'h10 + i));
        end
        chk("b_pulse_count", pulses.size(), exp_b.size());
        for (int k = 0; k < pulses.size() && k < exp_b.size(); k++) begin
            chk($sformatf("b_byte%0d", k), pulses[k].b, exp_b[k]);
            if (k > 0) chk($sformatf("b_spacing%0d", k), (pulses[k].c - pulses[k-1].c) >= 2, 1'b1);
        end

        // Back-pressure: channel not ready for 20 cycles with requester 1 full.
        pulses.delete();
        data_up_ready = 1'b0;
        req_valid = 4'b0010;
        req_data = {8'h00, 8'h00, 8'h5C, 8'h00};
        next_cycle();
        req_valid = '0;
        run(20);
        @(negedge clk);
        chk("c_no_pulse", pulses.size(), 0);
        chk("c_busy", busy, 1'b1);
        chk("c_ready1_low", req_ready[1], 1'b0);
        next_cycle();
        data_up_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("c_pulse_after_ready", data_up_valid, 1'b1);
        chk("c_byte", data_up, TAG ? 8'hF1 : 8'h5C);
        run(10);

        // Clock enable held low while a transfer is pending.
        data_up_ready = 1'b0;
        req_valid = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h00, 8'h77};
        next_cycle();
        req_valid = '0;
        run(3);
        ce = 1'b0;
        data_up_ready = 1'b1;
        req_valid = 4'b0010;
        req_data = {8'h00, 8'h00, 8'h66, 8'h00};
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            chk("d_frozen_valid", data_up_valid, 1'b0);
            chk("d_frozen_busy", busy, 1'b1);
            chk("d_frozen_ready", req_ready, 4'b1110);
        end
        next_cycle();
        ce = 1'b1;
        req_valid = '0;
        next_cycle();
        @(negedge clk);
        chk("d_resume_pulse", data_up_valid, 1'b1);
        chk("d_resume_byte", data_up, TAG ? 8'hF0 : 8'h77);
        run(10);

        // Reset asserted in the GAP right after the first pulse of a transfer.
        pulses.delete();
        data_up_ready = 1'b1;
        req_valid = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h00, 8'h99};
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("e_rst_valid", data_up_valid, 1'b0);
        chk("e_rst_ready", req_ready, 4'hF);
        chk("e_rst_busy", busy, 1'b0);
        next_cycle();
        rst = 1'b0;
        run(10);
        chk("e_no_pulse_after", pulses.size(), 0);

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            ce = ($urandom_range(0, 7) != 0);
            data_up_ready = ($urandom_range(0, 3) != 0);
            req_valid = N'($urandom);
            req_data = $urandom;
            next_cycle();
        end
        rst = 1'b0;
        ce = 1'b1;
        req_valid = '0;
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iurt_up_arbiter.md
IURT_UP_ARBITER -- requirements
Module: iurt_up_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of byte requesters sharing the up-channel; legal range 2..16.
REQ-002 SHALL have port clk  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ce  input  1  clock enable; every register updates only when ce=1.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester byte offered.
REQ-006 SHALL have port req_data  input  8*N_REQ  requester i byte on bits [8i+7:8i].
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester holding register empty.
REQ-008 SHALL have port data_up_ready  input  1  up-channel can accept one byte (level).
REQ-009 SHALL have port data_up_valid  output  1  one-cycle byte-transfer pulse.
REQ-010 SHALL have port data_up  output  8  byte qualified by data_up_valid.
REQ-011 SHALL have port busy  output  1  high while state is not IDLE.

Function
REQ-012 SHALL hold one 8-bit register plus full flag per requester; req_ready[i] = ~full[i], combinational.
REQ-013 SHALL capture req_data[i] and set full[i] at an edge with ce & req_valid[i] & ~full[i]; requesters qualify handshakes with ce.
REQ-014 SHALL run FSM states IDLE, SEND_TAG, SEND_DATA, GAP; reset state IDLE.
REQ-015 SHALL in IDLE, if any full flag is set, grant the first full requester searching round-robin from last_grant+1 (wrapping at N_REQ-1 to 0), store grant, go to SEND_TAG if tagging is compiled in, else SEND_DATA.
REQ-016 SHALL in SEND_TAG/SEND_DATA wait while data_up_ready=0; when data_up_ready=1, register data_up_valid=1 with the tag or held byte, then go to GAP.
REQ-017 SHALL hold data_up_valid high for exactly one ce-cycle per byte; GAP lasts one ce-cycle and ignores data_up_ready (minimum 2 cycles between pulses).
REQ-018 SHALL in GAP go to SEND_DATA after a tag, or, after data, clear full[grant], set last_grant=grant, go IDLE.
REQ-019 SHALL latency: byte captured at edge k -> data_up_valid after edge k+2 (untagged) when idle and data_up_ready=1.
REQ-020 SHALL allow a requester to refill its register no earlier than the edge after its full flag clears; a granted byte never changes while pending.
REQ-021 SHALL deliver bytes of one requester in capture order; no byte is dropped or duplicated.
REQ-022 SHALL, with all N_REQ full continuously, serve each requester exactly once per N_REQ grants.
REQ-023 SHALL keep data_up stable between pulses (last sent value).

Reset
REQ-024 SHALL on rst: state IDLE, all full=0 (req_ready all 1), data_up_valid=0, busy=0, last_grant=N_REQ-1; data_up and holding registers undefined.
REQ-025 SHALL on rst mid-transfer discard all held and in-flight bytes; no partial tag/data pair is emitted after reset release.

Configuration
REQ-026 SHALL compile tagging in with macro IURT_ARB_TAG_EN: each data byte preceded by tag byte 8'hF0 | grant[3:0]; earliest data pulse after edge k+4.
REQ-027 SHALL without IURT_ARB_TAG_EN omit SEND_TAG entirely; data bytes only, requester identity not transmitted.

Structure
REQ-028 SHALL place the FSM state enum and TAG_BASE (8'hF0) in shared package iurt_pkg.
REQ-029 SHALL implement the round-robin search as sub-module iurt_rr_pick (inputs request vector, last grant; outputs grant index, any).

Verification
REQ-030 SHALL cover: requester 2 sends 8'hA5, data_up_ready=1, untagged -> data_up_valid one cycle, data_up=8'hA5, 2 edges after capture.
REQ-031 SHALL cover: all four full, bytes 8'h10..8'h13, last_grant=3 -> output order 8'h10,8'h11,8'h12,8'h13, pulses >=2 cycles apart.
REQ-032 SHALL cover: data_up_ready held 0 for 20 cycles with requester 1 full -> no pulse, busy=1, req_ready[1]=0; ready rises -> single pulse next edge.
REQ-033 SHALL cover: IURT_ARB_TAG_EN, requester 3 sends 8'h42 -> pulses 8'hF3 then 8'h42, two cycles apart.
REQ-034 SHALL cover: ce held 0 for 5 cycles mid-SEND_DATA -> state, data_up_valid and flags frozen; resumes identically.
REQ-035 SHALL cover: rst asserted in GAP after tag -> data_up_valid=0, req_ready all 1, no data byte emitted after release.
